// File: rtl/simon_draw_ctrl_pkg.sv
// Shared definitions for the Simon Says square-drawing path: state encoding and
// geometry constants used by the draw controller, the datapath and the game FSM.
package simon_draw_ctrl_pkg;

  localparam int COORD_W = 7;
  localparam int COL_W   = 3;
  localparam int SIDE    = 4;
  localparam int PIX_W   = 4;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(SIDE * SIDE - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    LOAD_Y,
    LOAD_COL,
    DRAW,
    DONE
  } state_e;

endpackage

// File: rtl/simon_draw_ctrl.sv
// Draw controller: accepts one square request, strobes x/y/colour into the
// datapath, then plots every pixel of the SIDE x SIDE square and pulses done.
module simon_draw_ctrl
  import simon_draw_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               req,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [COL_W-1:0]   colour_in,
  output logic               busy,
  output logic               done,
  output logic               ld_x,
  output logic               ld_y,
  output logic               ld_colour,
  output logic [COORD_W-1:0] coordinate,
  output logic [COL_W-1:0]   colour_out,
  output logic [PIX_W-1:0]   pix_idx,
  output logic               plot
);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [PIX_W-1:0]   pix_q, pix_d;

  logic               busy_q, done_q, ld_x_q, ld_y_q, ld_col_q, plot_q;
  logic [COORD_W-1:0] coord_q;
  logic [COL_W-1:0]   colour_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    pix_d   = pix_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = LOAD_X;
          x_d     = x_in;
          y_d     = y_in;
          col_d   = colour_in;
        end
      end
      LOAD_X:   state_d = LOAD_Y;
      LOAD_Y:   state_d = LOAD_COL;
      LOAD_COL: begin
        state_d = DRAW;
        pix_d   = '0;
      end
      DRAW: begin
        // The increment past PIX_LAST wraps the index back to zero for the next square.
        pix_d = pix_q + 1'b1;
        if (pix_q == PIX_LAST) state_d = DONE;
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= '0;
      pix_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ld_x_q   <= 1'b0;
      ld_y_q   <= 1'b0;
      ld_col_q <= 1'b0;
      plot_q   <= 1'b0;
      coord_q  <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      pix_q    <= pix_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == DONE);
      ld_x_q   <= (state_d == LOAD_X);
      ld_y_q   <= (state_d == LOAD_Y);
      ld_col_q <= (state_d == LOAD_COL);
      plot_q   <= (state_d == DRAW);
      coord_q  <= (state_d == LOAD_X) ? x_d :
                  (state_d == LOAD_Y) ? y_d : '0;
      colour_q <= (state_d == LOAD_COL || state_d == DRAW || state_d == DONE) ? col_d : '0;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ld_x       = ld_x_q;
  assign ld_y       = ld_y_q;
  assign ld_colour  = ld_col_q;
  assign coordinate = coord_q;
  assign colour_out = colour_q;
  assign pix_idx    = pix_q;
  assign plot       = plot_q;

endmodule

// File: tb/tb_simon_draw_ctrl.sv
// Self-checking bench for simon_draw_ctrl: a vector table for the basic draw,
// hand-written reset/handshake sequences, and random requests against a timeline model.
module tb_simon_draw_ctrl;
  import simon_draw_ctrl_pkg::*;

  logic               clk;
  logic               resetn;
  logic               req;
  logic [COORD_W-1:0] xIn, yIn;
  logic [COL_W-1:0]   colourIn;
  logic               busy, done, ldX, ldY, ldColour, plot;
  logic [COORD_W-1:0] coordinate;
  logic [COL_W-1:0]   colourOut;
  logic [PIX_W-1:0]   pixIdx;

  simon_draw_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .x_in       (xIn),
    .y_in       (yIn),
    .colour_in  (colourIn),
    .busy       (busy),
    .done       (done),
    .ld_x       (ldX),
    .ld_y       (ldY),
    .ld_colour  (ldColour),
    .coordinate (coordinate),
    .colour_out (colourOut),
    .pix_idx    (pixIdx),
    .plot       (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         ldX;
    logic         ldY;
    logic         ldCol;
    logic [6:0]   coord;
    logic [2:0]   colour;
    logic [3:0]   pix;
    logic         plot;
  } outs_t;

  typedef struct {
    logic       req;
    logic [6:0] x;
    logic [6:0] y;
    logic [2:0] c;
    outs_t      exp;
  } vec_t;

  int passCount  = 0;
  int checkCount = 0;
  int cycle      = 0;

  // Reference model: a request is a 20-cycle timeline measured in edges since acceptance.
  bit         mActive = 1'b0;
  int         mK      = 0;
  logic [6:0] mX, mY;
  logic [2:0] mC;

  function automatic outs_t mkOut(input logic b, input logic d, input logic lx, input logic ly,
                                  input logic lc, input logic [6:0] co, input logic [2:0] cl,
                                  input logic [3:0] px, input logic pl);
    outs_t o;
    o.busy = b; o.done = d; o.ldX = lx; o.ldY = ly; o.ldCol = lc;
    o.coord = co; o.colour = cl; o.pix = px; o.plot = pl;
    return o;
  endfunction

  function automatic outs_t modelOut();
    outs_t o;
    o = '0;
    if (mActive) begin
      o.busy   = 1'b1;
      o.ldX    = (mK == 0);
      o.ldY    = (mK == 1);
      o.ldCol  = (mK == 2);
      o.coord  = (mK == 0) ? mX : (mK == 1) ? mY : 7'd0;
      o.colour = (mK >= 2) ? mC : 3'd0;
      o.plot   = (mK >= 3 && mK <= 18);
      o.pix    = o.plot ? 4'(mK - 3) : 4'd0;
      o.done   = (mK == 19);
    end
    return o;
  endfunction

  function automatic outs_t sampleDut();
    return mkOut(busy, done, ldX, ldY, ldColour, coordinate, colourOut, pixIdx, plot);
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("busy=%0b done=%0b ldx=%0b ldy=%0b ldc=%0b coord=%0d col=%0d pix=%0d plot=%0b",
                     o.busy, o.done, o.ldX, o.ldY, o.ldCol, o.coord, o.colour, o.pix, o.plot);
  endfunction

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = sampleDut();
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s @cycle %0d: got {%s} expected {%s}", name, cycle, fmt(act), fmt(exp));
  endtask

  task automatic applyStimulus(input logic r, input logic [6:0] x, input logic [6:0] y,
                               input logic [2:0] c);
    req = r; xIn = x; yIn = y; colourIn = c;
    @(posedge clk);
    cycle++;
    if (!resetn) mActive = 1'b0;
    else if (mActive) begin
      mK++;
      if (mK == 20) mActive = 1'b0;
    end else if (r) begin
      mActive = 1'b1; mK = 0; mX = x; mY = y; mC = c;
    end
    #1;
  endtask

  vec_t tbl[23];
  int   doneCycles[$];

  initial begin
    // Table for a basic draw; inputs change after accept and a stray req arrives during DRAW.
    tbl[0] = '{1'b1, 7'd10, 7'd20, 3'd4, mkOut(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd10, 3'd0, 4'd0, 1'b0)};
    tbl[1] = '{1'b0, 7'd99, 7'd88, 3'd1, mkOut(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'd20, 3'd0, 4'd0, 1'b0)};
    tbl[2] = '{1'b0, 7'd99, 7'd88, 3'd1, mkOut(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'd0,  3'd4, 4'd0, 1'b0)};
    for (int i = 0; i < 16; i++)
      tbl[3+i] = '{(i == 5), 7'd50, 7'd30, 3'd2,
                   mkOut(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 3'd4, 4'(i), 1'b1)};
    tbl[19] = '{1'b0, 7'd50, 7'd30, 3'd2, mkOut(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 3'd4, 4'd0, 1'b0)};
    for (int i = 20; i < 23; i++)
      tbl[i] = '{1'b0, 7'd50, 7'd30, 3'd2, '0};

    resetn = 1'b0; req = 1'b1; xIn = 7'd5; yIn = 7'd6; colourIn = 3'd7;
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("resetHold", '0);
    end
    @(negedge clk);
    resetn = 1'b1; req = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 7'd1, 7'd2, 3'd3);
    checkOutput("idleAfterReset", '0);

    for (int i = 0; i < 23; i++) begin
      applyStimulus(tbl[i].req, tbl[i].x, tbl[i].y, tbl[i].c);
      checkOutput($sformatf("table[%0d]", i), tbl[i].exp);
    end

    doneCycles.delete();
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 7'd0, 7'd0, 3'd7);
      checkOutput("heldReq", modelOut());
      if (done) doneCycles.push_back(cycle);
    end
    checkCount++;
    if (doneCycles.size() >= 2 && doneCycles[1] - doneCycles[0] == 21) passCount++;
    else $display("[TB] FAIL doneSpacing: got %0d pulses, gap %0d, expected gap 21",
                  doneCycles.size(), (doneCycles.size() >= 2) ? doneCycles[1] - doneCycles[0] : -1);
    for (int i = 0; i < 25; i++) applyStimulus(1'b0, 7'd0, 7'd0, 3'd0);
    checkOutput("drainedIdle", '0);

    applyStimulus(1'b1, 7'd33, 7'd44, 3'd5);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 7'd33, 7'd44, 3'd5);
    checkOutput("preResetPix7", mkOut(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 3'd5, 4'd7, 1'b1));
    #1 resetn = 1'b0;
    #1 checkOutput("asyncReset", '0);
    mActive = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, 7'd33, 7'd44, 3'd5);
      checkOutput("noDoneAfterReset", '0);
    end
    applyStimulus(1'b1, 7'd120, 7'd3, 3'd6);
    checkOutput("freshAccept", modelOut());
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b0, 7'd0, 7'd0, 3'd0);
      checkOutput("freshDraw", modelOut());
    end

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), 7'($urandom), 7'($urandom), 3'($urandom));
      checkOutput("random", modelOut());
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
